// File: rtl/video_timing_gen.sv
// video_timing_gen: parameterised VGA raster timing generator
// Ports:
//   clk            pixel clock
//   rst            synchronous reset, active-high
//   hc, vc         horizontal pixel / vertical line counters
//   display_enable high inside the active picture
//   hsync, vsync   sync pulses at HSYNC_POL / VSYNC_POL level while active
//   blank_n        DAC blank, identical to display_enable
//   line_start     one-cycle pulse on hc==0
//   frame_start    one-cycle pulse on hc==0 && vc==0
module video_timing_gen #(
    parameter int   HACTIVE   = 640,
    parameter int   HFP       = 16,
    parameter int   HSYNC     = 96,
    parameter int   HBP       = 48,
    parameter int   VACTIVE   = 480,
    parameter int   VFP       = 10,
    parameter int   VSYNC     = 2,
    parameter int   VBP       = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   CW        = 12
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic          display_enable,
    output logic          hsync,
    output logic          vsync,
    output logic          blank_n,
    output logic          line_start,
    output logic          frame_start
);
    localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
    localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;
    localparam logic [CW-1:0] H_LAST = CW'(HTOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(VTOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(HACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(VACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(HACTIVE + HFP);
    localparam logic [CW-1:0] H_SE   = CW'(HACTIVE + HFP + HSYNC);
    localparam logic [CW-1:0] V_SS   = CW'(VACTIVE + VFP);
    localparam logic [CW-1:0] V_SE   = CW'(VACTIVE + VFP + VSYNC);

    // run is low for the first edge after reset so (0,0) is held one extra cycle
    logic          run;
    logic          h_wrap;
    logic [CW-1:0] hn;
    logic [CW-1:0] vn;
    logic          de_n;
    logic          hs_on;
    logic          vs_on;

    // decode the next counter values so registered outputs line up with hc/vc
    always_comb begin
        h_wrap = hc == H_LAST;
        hn     = !run ? '0 : h_wrap ? '0 : hc + 1'b1;
        vn     = !run ? '0 : !h_wrap ? vc : (vc == V_LAST) ? '0 : vc + 1'b1;
        de_n   = (hn < H_ACT) && (vn < V_ACT);
        hs_on  = (hn >= H_SS) && (hn < H_SE);
        vs_on  = (vn >= V_SS) && (vn < V_SE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run            <= 1'b0;
            hc             <= '0;
            vc             <= '0;
            display_enable <= 1'b0;
            blank_n        <= 1'b0;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            hsync          <= ~HSYNC_POL;
            vsync          <= ~VSYNC_POL;
        end else begin
            run            <= 1'b1;
            hc             <= hn;
            vc             <= vn;
            display_enable <= de_n;
            blank_n        <= de_n;
            line_start     <= hn == '0;
            frame_start    <= (hn == '0) && (vn == '0);
            hsync          <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync          <= vs_on ? VSYNC_POL : ~VSYNC_POL;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen in three modes
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    logic [11:0] a_hc, a_vc, b_hc, b_vc, c_hc, c_vc;
    logic a_de, a_hs, a_vs, a_bn, a_ls, a_fs;
    logic b_de, b_hs, b_vs, b_bn, b_ls, b_fs;
    logic c_de, c_hs, c_vs, c_bn, c_ls, c_fs;

    always #5 clk = ~clk;

    video_timing_gen ua (.clk(clk), .rst(rst_a), .hc(a_hc), .vc(a_vc), .display_enable(a_de),
        .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn), .line_start(a_ls), .frame_start(a_fs));

    video_timing_gen #(.HACTIVE(8), .HFP(2), .HSYNC(3), .HBP(1), .VACTIVE(4), .VFP(1), .VSYNC(1), .VBP(1))
    ub (.clk(clk), .rst(rst_b), .hc(b_hc), .vc(b_vc), .display_enable(b_de),
        .hsync(b_hs), .vsync(b_vs), .blank_n(b_bn), .line_start(b_ls), .frame_start(b_fs));

    video_timing_gen #(.VACTIVE(4), .VFP(1), .VSYNC(2), .VBP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1))
    uc (.clk(clk), .rst(rst_c), .hc(c_hc), .vc(c_vc), .display_enable(c_de),
        .hsync(c_hs), .vsync(c_vs), .blank_n(c_bn), .line_start(c_ls), .frame_start(c_fs));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model parameters per instance (a, b, c)
    int ha[3] = '{640, 8, 640};
    int hf[3] = '{16, 2, 16};
    int hw[3] = '{96, 3, 96};
    int hb[3] = '{48, 1, 48};
    int va[3] = '{480, 4, 4};
    int vf[3] = '{10, 1, 1};
    int vw[3] = '{2, 1, 2};
    int vb[3] = '{33, 1, 1};
    bit hp[3] = '{1'b0, 1'b0, 1'b1};
    bit vp[3] = '{1'b0, 1'b0, 1'b1};
    int mh[3] = '{0, 0, 0};
    int mv[3] = '{0, 0, 0};
    bit mheld[3] = '{1'b1, 1'b1, 1'b1};
    bit minr[3] = '{1'b1, 1'b1, 1'b1};

    logic [29:0] sb[$];

    task automatic mstep(input int i, input bit r);
        if (r) begin
            mh[i] = 0; mv[i] = 0; mheld[i] = 1'b1; minr[i] = 1'b1;
        end else begin
            minr[i] = 1'b0;
            if (mheld[i]) mheld[i] = 1'b0;
            else begin
                mh[i]++;
                if (mh[i] == ha[i] + hf[i] + hw[i] + hb[i]) begin
                    mh[i] = 0;
                    mv[i]++;
                    if (mv[i] == va[i] + vf[i] + vw[i] + vb[i]) mv[i] = 0;
                end
            end
        end
    endtask

    function automatic logic [29:0] mout(input int i);
        bit de, hs, vs;
        if (minr[i]) return {24'd0, 1'b0, ~hp[i], ~vp[i], 3'b000};
        de = mh[i] < ha[i] && mv[i] < va[i];
        hs = (mh[i] >= ha[i] + hf[i] && mh[i] < ha[i] + hf[i] + hw[i]) ? hp[i] : ~hp[i];
        vs = (mv[i] >= va[i] + vf[i] && mv[i] < va[i] + vf[i] + vw[i]) ? vp[i] : ~vp[i];
        return {12'(mh[i]), 12'(mv[i]), de, hs, vs, de, mh[i] == 0, mh[i] == 0 && mv[i] == 0};
    endfunction

    bit meas = 1'b0;
    int cyc = 0;
    logic a_de_p = 1'b0, a_hs_p = 1'b1, b_hs_p = 1'b1, b_vs_p = 1'b1;
    int a_last_ls = -1, a_ls_per = 0, a_de_fall = -1, a_hs_start = -1, a_hs_len = 0, a_hs_run = 0, a_hc_max = 0;
    int b_last_fs = -1, b_fs_per = 0, b_de_cnt = 0, b_vs_cnt = 0, b_de_fr = 0, b_vs_fr = 0;
    int b_hs_start = -1, b_hs_len = 0, b_hs_run = 0, b_vs_vc = -1, b_vs_hc = -1;
    int c_bad = 0, c_vs_cnt = 0, c_hs_cnt = 0;

    task automatic cycle();
        logic [29:0] ea, eb, ec;
        mstep(0, rst_a); sb.push_back(mout(0));
        mstep(1, rst_b); sb.push_back(mout(1));
        mstep(2, rst_c); sb.push_back(mout(2));
        @(posedge clk);
        #1;
        cyc++;
        ea = sb.pop_front(); eb = sb.pop_front(); ec = sb.pop_front();
        chk("mdl_a", {a_hc, a_vc, a_de, a_hs, a_vs, a_bn, a_ls, a_fs}, ea);
        chk("mdl_b", {b_hc, b_vc, b_de, b_hs, b_vs, b_bn, b_ls, b_fs}, eb);
        chk("mdl_c", {c_hc, c_vc, c_de, c_hs, c_vs, c_bn, c_ls, c_fs}, ec);
        if (meas) begin
            if (a_ls) begin
                if (a_last_ls >= 0) a_ls_per = cyc - a_last_ls;
                a_last_ls = cyc;
            end
            if (a_de_p && !a_de) a_de_fall = int'(a_hc);
            if (!a_hs) begin
                if (a_hs_p) a_hs_start = int'(a_hc);
                a_hs_run++;
            end else if (!a_hs_p) begin
                a_hs_len = a_hs_run; a_hs_run = 0;
            end
            if (int'(a_hc) > a_hc_max) a_hc_max = int'(a_hc);
            if (b_fs) begin
                if (b_last_fs >= 0) begin
                    b_fs_per = cyc - b_last_fs; b_de_fr = b_de_cnt; b_vs_fr = b_vs_cnt;
                end
                b_last_fs = cyc; b_de_cnt = 0; b_vs_cnt = 0;
            end
            b_de_cnt += int'(b_de);
            b_vs_cnt += int'(!b_vs);
            if (!b_vs && b_vs_p) begin
                b_vs_vc = int'(b_vc); b_vs_hc = int'(b_hc);
            end
            if (!b_hs) begin
                if (b_hs_p) b_hs_start = int'(b_hc);
                b_hs_run++;
            end else if (!b_hs_p) begin
                b_hs_len = b_hs_run; b_hs_run = 0;
            end
            if (c_hs != (c_hc >= 656 && c_hc < 752)) c_bad++;
            if (c_vs != (c_vc == 5 || c_vc == 6)) c_bad++;
            c_vs_cnt += int'(c_vs);
            c_hs_cnt += int'(c_hs);
        end
        a_de_p = a_de; a_hs_p = a_hs; b_hs_p = b_hs; b_vs_p = b_vs;
    endtask

    initial begin
        int k;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (5) cycle();
        chk("rst_hc", a_hc, 0);
        chk("rst_vc", a_vc, 0);
        chk("rst_de", a_de, 0);
        chk("rst_bn", a_bn, 0);
        chk("rst_hs", a_hs, 1);
        chk("rst_vs", a_vs, 1);
        chk("rst_pol_hs", c_hs, 0);
        chk("rst_pol_vs", c_vs, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        cycle();
        chk("rel_hc", a_hc, 0);
        chk("rel_de", a_de, 1);
        chk("rel_bn", a_bn, 1);
        chk("rel_ls", a_ls, 1);
        chk("rel_fs", a_fs, 1);
        cycle();
        chk("rel_hc1", a_hc, 1);
        meas = 1'b1;
        repeat (6500) cycle();
        meas = 1'b0;
        chk("a_de_fall", a_de_fall, 640);
        chk("a_hs_start", a_hs_start, 656);
        chk("a_hs_len", a_hs_len, 96);
        chk("a_ls_per", a_ls_per, 800);
        chk("a_hc_max", a_hc_max, 799);
        chk("b_fs_per", b_fs_per, 98);
        chk("b_de_frame", b_de_fr, 32);
        chk("b_vs_frame", b_vs_fr, 14);
        chk("b_vs_vc", b_vs_vc, 5);
        chk("b_vs_hc", b_vs_hc, 0);
        chk("b_hs_start", b_hs_start, 10);
        chk("b_hs_len", b_hs_len, 3);
        chk("c_pol_bad", c_bad, 0);
        chk("c_vs_cnt", c_vs_cnt, 1600);
        chk("c_hs_cnt", c_hs_cnt, 96 * 8);
        k = 0;
        while (!(b_vc == 3 && b_hc == 5) && k < 200) begin
            cycle();
            k++;
        end
        chk("mid_wait", k < 200, 1);
        rst_b = 1'b1;
        cycle();
        chk("mid_hc", b_hc, 0);
        chk("mid_vc", b_vc, 0);
        chk("mid_de", b_de, 0);
        rst_b = 1'b0;
        cycle();
        chk("mid_fs", b_fs, 1);
        chk("mid_hc2", b_hc, 0);
        chk("mid_vc2", b_vc, 0);
        repeat (300) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
